// File: rtl/cache_pkg.sv
// Shared cache-side types and widths for the core/cache boundary.
// Address layout is {tag, index, offset}.
package cache_pkg;

    localparam int CACHE_ADDR_W   = 27;
    localparam int CACHE_DATA_W   = 32;
    localparam int CACHE_TAG_W    = 13;
    localparam int CACHE_INDEX_W  = 10;
    localparam int CACHE_OFFSET_W = 4;

    typedef enum logic {IDLE, WAIT} arb_state_t;
    typedef enum logic {OP_RD, OP_WR} op_t;

    // Write wins when a requester pulses both enables in one cycle.
    function automatic op_t op_of(input logic wr_en);
        return wr_en ? OP_WR : OP_RD;
    endfunction

endpackage

// File: rtl/cache_req_slot.sv
// One-deep request slot for a single requester: captures a pulsed request,
// holds it until the arbiter frees it, and flags protocol overruns.
module cache_req_slot
    import cache_pkg::*;
#(
    parameter int ADDR_W = CACHE_ADDR_W,
    parameter int DATA_W = CACHE_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              free,
    output logic              busy,
    output op_t               op,
    output logic [ADDR_W-1:0] slot_addr,
    output logic [DATA_W-1:0] slot_data,
    output logic              err_overrun
);

    logic pulse;
    assign pulse = rd_en | wr_en;

    // NOTE: state is updated with <= so every register in this block samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            op          <= OP_RD;
            // NOTE: the payload is reset as well so nothing downstream can
            // observe stale X data after rst, even though busy guards it.
            slot_addr   <= '0;
            slot_data   <= '0;
            err_overrun <= 1'b0;
        end else begin
            if (free) begin
                busy <= 1'b0;
            end
            if (pulse && !busy) begin
                busy      <= 1'b1;
                op        <= op_of(wr_en);
                slot_addr <= addr;
                slot_data <= wr_data;
            end
            if ((pulse && busy) || (rd_en && wr_en)) begin
                err_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing the single core-side cache port between
// instruction fetch (requester 0) and load/store (requester 1).
module cache_port_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W      = CACHE_ADDR_W,
    parameter int DATA_W      = CACHE_DATA_W,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        rq_rd_en,
    input  logic [1:0]        rq_wr_en,
    input  logic [ADDR_W-1:0] rq0_addr,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic [DATA_W-1:0] rq0_wr_data,
    input  logic [DATA_W-1:0] rq1_wr_data,
    output logic [1:0]        rq_busy,
    output logic [1:0]        rq_rd_fin,
    output logic [1:0]        rq_wr_fin,
    output logic [DATA_W-1:0] rq_rd_data,
    output logic              core2cache_rd_en,
    output logic              core2cache_wr_en,
    output logic [ADDR_W-1:0] core2cache_rd_addr,
    output logic [ADDR_W-1:0] core2cache_wr_addr,
    output logic [DATA_W-1:0] core2cache_wr_data,
    input  logic              cache2core_rd_fin,
    input  logic              cache2core_wr_fin,
    input  logic [DATA_W-1:0] cache2core_rd_data,
    output logic [1:0]        err_overrun,
    output logic              err_timeout
);

    localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYC - 1);

    logic [ADDR_W-1:0] rq_addr   [2];
    logic [DATA_W-1:0] rq_data   [2];
    op_t               slot_op   [2];
    logic [ADDR_W-1:0] slot_addr [2];
    logic [DATA_W-1:0] slot_data [2];
    logic [1:0]        slot_free;

    assign rq_addr[0] = rq0_addr;
    assign rq_addr[1] = rq1_addr;
    assign rq_data[0] = rq0_wr_data;
    assign rq_data[1] = rq1_wr_data;

    for (genvar i = 0; i < 2; i++) begin : g_slot
        cache_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
            .clk         (clk),
            .rst         (rst),
            .rd_en       (rq_rd_en[i]),
            .wr_en       (rq_wr_en[i]),
            .addr        (rq_addr[i]),
            .wr_data     (rq_data[i]),
            .free        (slot_free[i]),
            .busy        (rq_busy[i]),
            .op          (slot_op[i]),
            .slot_addr   (slot_addr[i]),
            .slot_data   (slot_data[i]),
            .err_overrun (err_overrun[i])
        );
    end

    arb_state_t state;
    op_t        cur_op;
    logic       grant;
    logic       last_grant;
    logic [9:0] wait_cnt;

    logic arb_grant;
    logic fin_match;
    logic timeout_hit;
    logic done;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        arb_grant   = 1'b0;
        fin_match   = 1'b0;
        timeout_hit = 1'b0;
        slot_free   = 2'b00;
        if (&rq_busy) begin
            arb_grant = ~last_grant;
        end else begin
            arb_grant = rq_busy[1];
        end
        if (state == WAIT) begin
            fin_match   = (cur_op == OP_WR) ? cache2core_wr_fin : cache2core_rd_fin;
            timeout_hit = (wait_cnt == TO_LAST);
        end
        done = fin_match || timeout_hit;
        if (done) begin
            slot_free[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            cur_op             <= OP_RD;
            grant              <= 1'b0;
            last_grant         <= 1'b1;
            wait_cnt           <= '0;
            rq_rd_fin          <= '0;
            rq_wr_fin          <= '0;
            rq_rd_data         <= '0;
            core2cache_rd_en   <= 1'b0;
            core2cache_wr_en   <= 1'b0;
            core2cache_rd_addr <= '0;
            core2cache_wr_addr <= '0;
            core2cache_wr_data <= '0;
            err_timeout        <= 1'b0;
        end else begin
            core2cache_rd_en <= 1'b0;
            core2cache_wr_en <= 1'b0;
            rq_rd_fin        <= '0;
            rq_wr_fin        <= '0;
            case (state)
                IDLE: begin
                    if (|rq_busy) begin
                        grant      <= arb_grant;
                        last_grant <= arb_grant;
                        cur_op     <= slot_op[arb_grant];
                        wait_cnt   <= '0;
                        state      <= WAIT;
                        if (slot_op[arb_grant] == OP_WR) begin
                            core2cache_wr_en   <= 1'b1;
                            core2cache_wr_addr <= slot_addr[arb_grant];
                            core2cache_wr_data <= slot_data[arb_grant];
                        end else begin
                            core2cache_rd_en   <= 1'b1;
                            core2cache_rd_addr <= slot_addr[arb_grant];
                        end
                    end
                end
                WAIT: begin
                    if (done) begin
                        if (cur_op == OP_WR) begin
                            rq_wr_fin[grant] <= 1'b1;
                        end else begin
                            rq_rd_fin[grant] <= 1'b1;
                            // An aborted read returns zero rather than bus garbage.
                            rq_rd_data <= fin_match ? cache2core_rd_data : '0;
                        end
                        if (!fin_match) begin
                            err_timeout <= 1'b1;
                        end
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 10'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench: stimulus pushes expected cache accesses and requester
// completions; a negedge monitor pops and compares them as the DUT emits.
module tb_cache_port_arbiter;
    import cache_pkg::*;

    localparam int AW = CACHE_ADDR_W;
    localparam int DW = CACHE_DATA_W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    rq_rd_en = '0, rq_wr_en = '0;
    logic [AW-1:0] rq0_addr = '0, rq1_addr = '0;
    logic [DW-1:0] rq0_wr_data = '0, rq1_wr_data = '0;
    logic [1:0]    rq_busy, rq_rd_fin, rq_wr_fin, err_overrun;
    logic [DW-1:0] rq_rd_data;
    logic          core2cache_rd_en, core2cache_wr_en;
    logic [AW-1:0] core2cache_rd_addr, core2cache_wr_addr;
    logic [DW-1:0] core2cache_wr_data;
    logic          cache2core_rd_fin = 1'b0, cache2core_wr_fin = 1'b0;
    logic [DW-1:0] cache2core_rd_data = '0;
    logic          err_timeout;

    cache_port_arbiter dut (
        .clk(clk), .rst(rst),
        .rq_rd_en(rq_rd_en), .rq_wr_en(rq_wr_en),
        .rq0_addr(rq0_addr), .rq1_addr(rq1_addr),
        .rq0_wr_data(rq0_wr_data), .rq1_wr_data(rq1_wr_data),
        .rq_busy(rq_busy), .rq_rd_fin(rq_rd_fin), .rq_wr_fin(rq_wr_fin),
        .rq_rd_data(rq_rd_data),
        .core2cache_rd_en(core2cache_rd_en), .core2cache_wr_en(core2cache_wr_en),
        .core2cache_rd_addr(core2cache_rd_addr), .core2cache_wr_addr(core2cache_wr_addr),
        .core2cache_wr_data(core2cache_wr_data),
        .cache2core_rd_fin(cache2core_rd_fin), .cache2core_wr_fin(cache2core_wr_fin),
        .cache2core_rd_data(cache2core_rd_data),
        .err_overrun(err_overrun), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct { op_t op; logic [AW-1:0] addr; logic [DW-1:0] data; } acc_t;
    typedef struct { int req; op_t op; logic [DW-1:0] data; } fin_t;

    acc_t exp_acc[$];
    fin_t exp_fin[$];
    acc_t m_acc;
    fin_t m_fin;
    int   n_checks = 0, n_pass = 0, n_acc = 0, n_fin = 0, cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(posedge clk) cyc++;

    // Monitor: compare every cache access and every requester fin against the queues.
    always @(negedge clk) begin
        if (core2cache_rd_en || core2cache_wr_en) begin
            n_acc++;
            if (exp_acc.size() == 0) begin
                check("unexpected cache access", 1, 0);
            end else begin
                m_acc = exp_acc.pop_front();
                check("cache en pair", {core2cache_rd_en, core2cache_wr_en},
                      (m_acc.op == OP_WR) ? 2'b01 : 2'b10);
                if (m_acc.op == OP_WR) begin
                    check("cache wr addr", core2cache_wr_addr, m_acc.addr);
                    check("cache wr data", core2cache_wr_data, m_acc.data);
                end else begin
                    check("cache rd addr", core2cache_rd_addr, m_acc.addr);
                end
            end
        end
        if ((|rq_rd_fin) || (|rq_wr_fin)) begin
            n_fin++;
            check("one rq fin at a time", $countones({rq_rd_fin, rq_wr_fin}), 1);
            if (exp_fin.size() == 0) begin
                check("unexpected rq fin", 1, 0);
            end else begin
                m_fin = exp_fin.pop_front();
                check("rq_rd_fin", rq_rd_fin, (m_fin.op == OP_RD) ? (2'b01 << m_fin.req) : 2'b00);
                check("rq_wr_fin", rq_wr_fin, (m_fin.op == OP_WR) ? (2'b01 << m_fin.req) : 2'b00);
                if (m_fin.op == OP_RD) check("rq_rd_data", rq_rd_data, m_fin.data);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic set_req(input int req, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        rq_rd_en[req] = rd;
        rq_wr_en[req] = wr;
        if (req == 0) begin rq0_addr = a; rq0_wr_data = d; end
        else          begin rq1_addr = a; rq1_wr_data = d; end
    endtask

    task automatic pulse(input int req, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        set_req(req, rd, wr, a, d);
        tick();
        rq_rd_en = '0;
        rq_wr_en = '0;
    endtask

    task automatic push_acc(input op_t op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        acc_t e;
        e.op = op; e.addr = a; e.data = d;
        exp_acc.push_back(e);
    endtask

    task automatic push_fin(input int req, input op_t op, input logic [DW-1:0] d);
        fin_t e;
        e.req = req; e.op = op; e.data = d;
        exp_fin.push_back(e);
    endtask

    // Returns with the cache enable visible; c = ticks waited.
    task automatic wait_en(output int c);
        c = 0;
        while (!(core2cache_rd_en || core2cache_wr_en) && c < 2000) begin
            tick();
            c++;
        end
        if (!(core2cache_rd_en || core2cache_wr_en)) check("cache en wait bound", 0, 1);
    endtask

    task automatic wait_rq_fin(output int c);
        c = 0;
        while (!((|rq_rd_fin) || (|rq_wr_fin)) && c < 2000) begin
            tick();
            c++;
        end
        if (!((|rq_rd_fin) || (|rq_wr_fin))) check("rq fin wait bound", 0, 1);
    endtask

    task automatic cache_fin(input logic wr, input logic [DW-1:0] d);
        cache2core_rd_fin  = !wr;
        cache2core_wr_fin  = wr;
        cache2core_rd_data = d;
        tick();
        cache2core_rd_fin  = 1'b0;
        cache2core_wr_fin  = 1'b0;
        cache2core_rd_data = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"}, rq_busy, 2'b00);
        check({tag, " rq fins"}, {rq_rd_fin, rq_wr_fin}, 4'b0000);
        check({tag, " rd_data"}, rq_rd_data, 32'h0);
        check({tag, " cache en"}, {core2cache_rd_en, core2cache_wr_en}, 2'b00);
        check({tag, " cache addr/data"}, {core2cache_rd_addr, core2cache_wr_addr, core2cache_wr_data}, 86'h0);
        check({tag, " errors"}, {err_overrun, err_timeout}, 3'b000);
    endtask

    int c, acc0, fin0, t_en;

    initial begin
        // Reset state
        tick(3);
        rst = 1'b0;
        check_idle_outputs("reset");

        // Single read, with a wrong-type fin ignored first
        acc0 = n_acc;
        push_acc(OP_RD, 27'h0012345, '0);
        pulse(0, 1, 0, 27'h0012345, '0);
        check("busy after capture", rq_busy, 2'b01);
        wait_en(c);
        check("issue latency", c, 1);
        cache_fin(1, '0);
        tick();
        push_fin(0, OP_RD, 32'hDEADBEEF);
        cache_fin(0, 32'hDEADBEEF);
        check("single read fin", rq_rd_fin, 2'b01);
        check("single read data", rq_rd_data, 32'hDEADBEEF);
        check("busy freed", rq_busy, 2'b00);
        tick(3);
        check("rd data holds", rq_rd_data, 32'hDEADBEEF);
        check("one cache access", n_acc - acc0, 1);

        // Simultaneous requests after reset: requester 0 first
        do_reset();
        push_acc(OP_RD, 27'h0000100, '0);
        push_acc(OP_WR, 27'h4000010, 32'h1);
        set_req(0, 1, 0, 27'h0000100, '0);
        set_req(1, 0, 1, 27'h4000010, 32'h1);
        tick();
        rq_rd_en = '0; rq_wr_en = '0;
        check("both busy", rq_busy, 2'b11);
        wait_en(c);
        tick(2);
        push_fin(0, OP_RD, 32'h11111111);
        cache_fin(0, 32'h11111111);
        wait_en(c);
        check("queued issue one edge after fin", c, 1);
        tick();
        push_fin(1, OP_WR, '0);
        cache_fin(1, '0);
        // Lone requester-0 read leaves last_grant=0, so the next pair goes 1 then 0
        push_acc(OP_RD, 27'h0000200, '0);
        pulse(0, 1, 0, 27'h0000200, '0);
        wait_en(c);
        tick();
        push_fin(0, OP_RD, 32'h22222222);
        cache_fin(0, 32'h22222222);
        push_acc(OP_WR, 27'h4000020, 32'h2);
        push_acc(OP_RD, 27'h0000300, '0);
        set_req(0, 1, 0, 27'h0000300, '0);
        set_req(1, 0, 1, 27'h4000020, 32'h2);
        tick();
        rq_rd_en = '0; rq_wr_en = '0;
        wait_en(c);
        tick();
        push_fin(1, OP_WR, '0);
        cache_fin(1, '0);
        wait_en(c);
        check("second of pair follows", c, 1);
        tick();
        push_fin(0, OP_RD, 32'h33333333);
        cache_fin(0, 32'h33333333);
        tick(2);

        // Overrun while busy, and rd+wr on the same requester
        do_reset();
        acc0 = n_acc;
        push_acc(OP_WR, 27'h0200000, 32'h11);
        pulse(1, 0, 1, 27'h0200000, 32'h11);
        check("busy 1", rq_busy, 2'b10);
        pulse(1, 0, 1, 27'h0200040, 32'h22);
        check("overrun flagged", err_overrun, 2'b10);
        wait_en(c);
        tick();
        push_fin(1, OP_WR, '0);
        cache_fin(1, '0);
        tick(3);
        check("overrun single access", n_acc - acc0, 1);
        check("overrun sticky", err_overrun, 2'b10);
        push_acc(OP_WR, 27'h0300000, 32'h33);
        pulse(0, 1, 1, 27'h0300000, 32'h33);
        check("rd+wr overrun", err_overrun, 2'b11);
        wait_en(c);
        tick();
        push_fin(0, OP_WR, '0);
        cache_fin(1, '0);
        do_reset();
        check("overrun cleared by rst", err_overrun, 2'b00);

        // Timeout with a queued write behind it
        push_acc(OP_RD, 27'h0000ABC, '0);
        pulse(0, 1, 0, 27'h0000ABC, '0);
        wait_en(c);
        tick();
        push_fin(0, OP_RD, 32'hCAFEF00D);
        cache_fin(0, 32'hCAFEF00D);
        push_acc(OP_RD, 27'h1234567, '0);
        pulse(0, 1, 0, 27'h1234567, '0);
        wait_en(c);
        t_en = cyc;
        push_acc(OP_WR, 27'h0777777, 32'h5A5A5A5A);
        pulse(1, 0, 1, 27'h0777777, 32'h5A5A5A5A);
        push_fin(0, OP_RD, 32'h0);
        wait_rq_fin(c);
        check("timeout latency", cyc - t_en, 1023);
        check("timeout fin", rq_rd_fin, 2'b01);
        check("timeout flag", err_timeout, 1'b1);
        wait_en(c);
        check("issue after timeout", c, 1);
        tick();
        push_fin(1, OP_WR, '0);
        cache_fin(1, '0);
        check("timeout sticky", err_timeout, 1'b1);

        // Reset mid-WAIT, late fin ignored, fresh request works
        do_reset();
        fin0 = n_fin;
        push_acc(OP_RD, 27'h0000F00, '0);
        pulse(0, 1, 0, 27'h0000F00, '0);
        wait_en(c);
        tick(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("mid-wait reset");
        cache_fin(0, 32'h12345678);
        tick(2);
        check("no fin after reset", n_fin - fin0, 0);
        push_acc(OP_RD, 27'h0000F04, '0);
        pulse(0, 1, 0, 27'h0000F04, '0);
        wait_en(c);
        check("fresh issue latency", c, 1);
        tick();
        push_fin(0, OP_RD, 32'h0A0B0C0D);
        cache_fin(0, 32'h0A0B0C0D);
        check("fresh read fin", rq_rd_fin, 2'b01);

        // Back-to-back re-pulse on requester 1
        do_reset();
        push_acc(OP_WR, 27'h0100000, 32'hAAAA0001);
        pulse(1, 0, 1, 27'h0100000, 32'hAAAA0001);
        wait_en(c);
        tick();
        push_fin(1, OP_WR, '0);
        cache_fin(1, '0);
        check("busy falls after fin", rq_busy, 2'b00);
        push_acc(OP_WR, 27'h0100004, 32'hAAAA0002);
        pulse(1, 0, 1, 27'h0100004, 32'hAAAA0002);
        wait_en(c);
        check("re-pulse issue latency", c, 1);
        tick();
        check("re-pulse no overrun", err_overrun, 2'b00);
        acc0 = n_acc;
        push_fin(1, OP_WR, '0);
        set_req(1, 0, 1, 27'h0100008, 32'hAAAA0003);
        cache_fin(1, '0);
        rq_rd_en = '0; rq_wr_en = '0;
        check("same-cycle re-pulse overrun", err_overrun, 2'b10);
        check("same-cycle re-pulse dropped", rq_busy, 2'b00);
        tick(3);
        check("no access for dropped pulse", n_acc - acc0, 0);

        tick(2);
        check("access queue drained", exp_acc.size(), 0);
        check("fin queue drained", exp_fin.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
